// File: rtl/maze_pkg.sv
// maze_pkg: shared maze constants and types for the movement logic.
//   MAZE_ROWS / MAZE_COLS : populated maze size in tiles
//   ROW_W / COL_W         : tile coordinate widths (ROW_W is also the wall-ROM address width)
//   dir_e                 : movement direction encoding used by every mover
//   tile_t                : a {row, col} tile coordinate
package maze_pkg;

  localparam int MAZE_ROWS = 24;
  localparam int MAZE_COLS = 32;
  localparam int ROW_W     = 5;
  localparam int COL_W     = 5;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tile_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over N request lines.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable_i     : 0 = issue no grant and hold the pointer
//   req_i        : request vector
//   grant_o      : one-hot grant (combinational, same cycle as the request)
//   grant_id_o   : index of the granted requester (valid when grant_any_o)
//   grant_any_o  : a grant is issued this cycle
//   ptr_o        : current priority pointer (debug visibility)
module rr_arbiter #(
  parameter  int N  = 5,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_id_o,
  output logic          grant_any_o,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  int            idx;

  // Scan from the pointer upwards with wrap; the first active request wins.
  always_comb begin
    grant_o     = '0;
    grant_id_o  = '0;
    grant_any_o = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (enable_i && !grant_any_o && req_i[idx]) begin
        grant_any_o  = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = PW'(idx);
      end
    end
  end

  // The winner drops to lowest priority next cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any_o) begin
      ptr_d = (grant_id_o == PW'(N - 1)) ? '0 : grant_id_o + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/maze_move_arbiter.sv
// maze_move_arbiter: shares one wall-ROM read port among the movers.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : 0 = no new grants (paused); in-flight ops still complete
//   req_valid/req_ready : per-requester handshake; a transfer happens in a
//                   cycle where req_valid[i] & req_ready[i]. req_ready is
//                   one-hot, combinational, and never waits on req_ready of
//                   another requester. Requesters hold req_row/col/dir stable
//                   while req_valid is high and not yet granted.
//   req_row/col/dir : source tile and desired direction per requester
//   rom_addr / rom_data : combinational wall-ROM port (bit 2**COL_WIDTH-1-c is column c)
//   resp_*        : one-cycle result strobe, two cycles after the handshake;
//                   no backpressure
//   dbg_ptr       : round-robin pointer, exposed for observation
// Pipeline: stage A grants and computes the target tile, stage B reads the
// ROM and resolves blocked/next tile into the response registers.
module maze_move_arbiter
  import maze_pkg::*;
#(
  parameter  int NUM_REQ   = 5,
  parameter  int ROW_WIDTH = ROW_W,
  parameter  int COL_WIDTH = COL_W,
  parameter  int NUM_ROWS  = MAZE_ROWS,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int WORD_W    = 2 ** COL_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][ROW_WIDTH-1:0]   req_row,
  input  logic [NUM_REQ-1:0][COL_WIDTH-1:0]   req_col,
  input  logic [NUM_REQ-1:0][1:0]             req_dir,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [ROW_WIDTH-1:0]                rom_addr,
  input  logic [WORD_W-1:0]                   rom_data,
  output logic                                resp_valid,
  output logic [ID_W-1:0]                     resp_id,
  output logic                                resp_blocked,
  output logic [ROW_WIDTH-1:0]                resp_row,
  output logic [COL_WIDTH-1:0]                resp_col,
  output logic [ID_W-1:0]                     dbg_ptr
);

  // ---------------- Stage A: grant + target tile ----------------
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic [ROW_WIDTH-1:0] src_row;
  logic [COL_WIDTH-1:0] src_col;
  logic [1:0]           src_dir;
  logic [ROW_WIDTH-1:0] b_trow_d;
  logic [COL_WIDTH-1:0] b_tcol_d;
  logic                 b_oob_d;

  // Gating with rst_n keeps req_ready low while reset is asserted.
  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable & rst_n),
    .req_i       (req_valid),
    .grant_o     (req_ready),
    .grant_id_o  (gnt_id),
    .grant_any_o (gnt_any),
    .ptr_o       (dbg_ptr)
  );

  assign src_row = req_row[gnt_id];
  assign src_col = req_col[gnt_id];
  assign src_dir = req_dir[gnt_id];

  // On an out-of-range move the target row stays at the source row, so the
  // ROM address below is simply the registered target row in every case.
  // Columns wrap naturally through the COL_WIDTH-bit arithmetic (tunnel).
  always_comb begin
    b_trow_d = src_row;
    b_tcol_d = src_col;
    b_oob_d  = 1'b0;
    case (dir_e'(src_dir))
      DIR_UP: begin
        if (src_row == '0) b_oob_d  = 1'b1;
        else               b_trow_d = src_row - ROW_WIDTH'(1);
      end
      DIR_DOWN: begin
        if (int'(src_row) + 1 >= NUM_ROWS) b_oob_d  = 1'b1;
        else                               b_trow_d = src_row + ROW_WIDTH'(1);
      end
      DIR_RIGHT: b_tcol_d = src_col + COL_WIDTH'(1);
      DIR_LEFT:  b_tcol_d = src_col - COL_WIDTH'(1);
      default:   ;
    endcase
  end

  // ---------------- Stage B: ROM lookup ----------------
  logic                 b_valid_q;
  logic [ID_W-1:0]      b_id_q;
  logic [ROW_WIDTH-1:0] b_srow_q, b_trow_q;
  logic [COL_WIDTH-1:0] b_scol_q, b_tcol_q;
  logic                 b_oob_q;
  logic                 b_blocked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
      b_srow_q  <= '0;
      b_scol_q  <= '0;
      b_trow_q  <= '0;
      b_tcol_q  <= '0;
      b_oob_q   <= 1'b0;
    end else begin
      b_valid_q <= gnt_any;
      if (gnt_any) begin
        b_id_q   <= gnt_id;
        b_srow_q <= src_row;
        b_scol_q <= src_col;
        b_trow_q <= b_trow_d;
        b_tcol_q <= b_tcol_d;
        b_oob_q  <= b_oob_d;
      end
    end
  end

  assign rom_addr = b_trow_q;

  // Column c lives at bit WORD_W-1-c; with WORD_W = 2**COL_WIDTH that index
  // is exactly the bitwise inverse of c.
  assign b_blocked = b_oob_q | rom_data[~b_tcol_q];

  // ---------------- Response registers ----------------
  logic                 resp_valid_q;
  logic [ID_W-1:0]      resp_id_q;
  logic                 resp_blocked_q;
  logic [ROW_WIDTH-1:0] resp_row_q;
  logic [COL_WIDTH-1:0] resp_col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_blocked_q <= 1'b0;
      resp_row_q     <= '0;
      resp_col_q     <= '0;
    end else begin
      resp_valid_q <= b_valid_q;
      if (b_valid_q) begin
        resp_id_q      <= b_id_q;
        resp_blocked_q <= b_blocked;
        resp_row_q     <= b_blocked ? b_srow_q : b_trow_q;
        resp_col_q     <= b_blocked ? b_scol_q : b_tcol_q;
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_blocked = resp_blocked_q;
  assign resp_row     = resp_row_q;
  assign resp_col     = resp_col_q;

endmodule

// File: doc/maze_move_arbiter.md
# maze_move_arbiter

Shares the single maze wall-ROM read port among the game's movers (Pac-Man plus ghosts). Each requester submits its current tile and a desired direction. The block arbitrates round-robin, computes the neighbouring target tile (horizontal tunnel wrap included), reads the wall row from the ROM, and returns whether the move is blocked along with the resulting next tile. It sits between the per-sprite movement FSMs and one read port of the wall ROM.

## Interface
- NUM_REQ, 5: number of requesters (index 0 = Pac-Man, 1-4 = ghosts)
- ROW_WIDTH, 5: row address bits; also the ROM address width
- COL_WIDTH, 5: column bits; ROM word width is 2**COL_WIDTH (32)
- NUM_ROWS, 24: rows actually populated in the ROM
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  0 = no new grants (game paused); in-flight ops complete
- req_valid  in  [NUM_REQ]  request pending per requester
- req_row  in  [NUM_REQ][ROW_WIDTH]  current row of requester
- req_col  in  [NUM_REQ][COL_WIDTH]  current column of requester
- req_dir  in  [NUM_REQ][2]  0 up, 1 right, 2 down, 3 left
- req_ready  out  [NUM_REQ]  one-hot grant; handshake when valid & ready
- rom_addr  out  ROW_WIDTH  row address to wall ROM (ROM read is combinational)
- rom_data  in  2**COL_WIDTH  wall row; column c is bit (2**COL_WIDTH-1-c); 1 = wall
- resp_valid  out  1  response strobe, one cycle
- resp_id  out  $clog2(NUM_REQ)  requester the response belongs to
- resp_blocked  out  1  1 = move not allowed
- resp_row, resp_col  out  ROW_WIDTH / COL_WIDTH  next tile: target if free, source if blocked

## Operation
- Stage A (grant): when enable=1, the round-robin arbiter picks the first requester with req_valid, starting at pointer ptr. req_ready is high for that requester only, combinationally, in the same cycle. Target tile is computed and registered into stage B along with source tile, id, and oob flag.
- Pointer: reset 0; after a grant to i, ptr = (i+1) mod NUM_REQ; unchanged with no grant.
- Target: up row-1, down row+1, left col-1, right col+1. Columns wrap mod 2**COL_WIDTH (0 left → 31, 31 right → 0).
- Out of range: row 0 up, or row+1 ≥ NUM_ROWS down, sets oob. oob → blocked=1 with no ROM dependency.
- Stage B (lookup): rom_addr = registered target row (oob: source row). blocked = oob | rom_data[2**COL_WIDTH-1-tcol]. Results are registered into the response outputs.
- No response backpressure. Requesters must sample resp_* when resp_valid=1 and resp_id matches.
- Requesters hold req_* stable while req_valid=1 and not yet granted.
- enable=0: req_ready all 0, and ptr is held.

## Timing
- Throughput: one grant per cycle.
- Latency: handshake in cycle N → resp_valid in cycle N+2.
- Reset (async assert, sync deassert by the system): req_ready 0, resp_valid 0, resp_blocked 0, resp_id/row/col 0, rom_addr 0, ptr 0, stage B valid 0.
- Reset mid-operation discards in-flight ops; no response is issued for them.
- Simultaneous requests resolve by ptr. Starvation bound: NUM_REQ-1 cycles while enable=1.

## Structure
- Shared package maze_pkg: dir_e enum (DIR_UP/RIGHT/DOWN/LEFT), MAZE_ROWS=24, MAZE_COLS=32, ROW_W, COL_W, tile_t struct {row, col}.
- Sub-module rr_arbiter (parameter N): req vector + enable → one-hot grant, owns ptr. Target computation and the two pipeline stages stay in maze_move_arbiter.

## Test plan
- Requester 0 at (4,6), dir right → resp N+2: id 0, blocked 0, next (4,7); rom_addr 4 in N+1.
- Requester 0 at (4,6), dir left → blocked 1, next (4,6) (bit 26 of row 4 is 1).
- Requester 2 at (12,0), dir left → rom_addr 12, target col 31, blocked 1, next (12,0).
- Requester 1 at (0,10) up; requester 3 at (23,10) down → both blocked 1 (oob), next equals source.
- All 5 req_valid held high from reset → grants 0,1,2,3,4,0 on consecutive cycles; responses in the same order 2 cycles later.
- enable=0 for 3 cycles with requests pending, then rst_n pulsed low while a response is in flight → no grants, resp_valid 0 during and after reset, ptr 0.
